// File: rtl/traffic_light_conflict_monitor.sv
// Lamp-side safety monitor: watches controller light codes for invalid, conflicting,
// out-of-order or short-yellow aspects and forces a red/dark flash once a fault latches.
module traffic_light_conflict_monitor #(
    parameter int MIN_YELLOW = 20,
    parameter int FLASH_HALF = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] highway_light,
    input  logic [1:0] farm_light,
    input  logic       fault_clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] lamp_highway,
    output logic [1:0] lamp_farm
);

    localparam int CW = $clog2(MIN_YELLOW + 1);
    localparam int FW = (FLASH_HALF > 1) ? $clog2(2 * FLASH_HALF) : 1;
    localparam logic [CW-1:0] YEL_MAX    = CW'(MIN_YELLOW);
    localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_HALF - 1);
    localparam logic [FW-1:0] FLASH_MID  = FW'(FLASH_HALF);

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;
    localparam logic [1:0] BAD    = 2'b11;

    typedef enum logic [2:0] {
        CAUSE_NONE           = 3'd0,
        CAUSE_INVALID        = 3'd1,
        CAUSE_CONFLICT       = 3'd2,
        CAUSE_SEQ_HW         = 3'd3,
        CAUSE_SEQ_FARM       = 3'd4,
        CAUSE_SHORT_YEL_HW   = 3'd5,
        CAUSE_SHORT_YEL_FARM = 3'd6
    } cause_e;

    logic [1:0]    prev_hw;
    logic [1:0]    prev_farm;
    logic [CW-1:0] yel_cnt_hw;
    logic [CW-1:0] yel_cnt_farm;
    logic [FW-1:0] flash_cnt;

    cause_e        cause;
    logic          violation;
    logic          clear_ok;
    logic          fault_n;
    logic [2:0]    fault_code_n;
    logic [FW-1:0] flash_cnt_n;
    logic [1:0]    lamp_hw_n;
    logic [1:0]    lamp_farm_n;

    function automatic logic illegal_step(input logic [1:0] from, input logic [1:0] to);
        return ((from == GREEN)  && (to == RED))   ||
               ((from == YELLOW) && (to == GREEN)) ||
               ((from == RED)    && (to == YELLOW));
    endfunction

    // Lowest-numbered cause wins when several checks fire together
    always_comb begin
        cause = CAUSE_NONE;
        if ((highway_light == BAD) || (farm_light == BAD))
            cause = CAUSE_INVALID;
        else if ((highway_light != RED) && (farm_light != RED))
            cause = CAUSE_CONFLICT;
        else if (illegal_step(prev_hw, highway_light))
            cause = CAUSE_SEQ_HW;
        else if (illegal_step(prev_farm, farm_light))
            cause = CAUSE_SEQ_FARM;
        else if ((prev_hw == YELLOW) && (highway_light == RED) && (yel_cnt_hw < YEL_MAX))
            cause = CAUSE_SHORT_YEL_HW;
        else if ((prev_farm == YELLOW) && (farm_light == RED) && (yel_cnt_farm < YEL_MAX))
            cause = CAUSE_SHORT_YEL_FARM;
    end

    assign violation = (cause != CAUSE_NONE);
    assign clear_ok  = fault && fault_clear && (highway_light == RED) && (farm_light == RED);

    // A violation coinciding with an accepted clear re-latches with the new cause
    always_comb begin
        fault_n      = fault;
        fault_code_n = fault_code;
        flash_cnt_n  = flash_cnt;
        lamp_hw_n    = highway_light;
        lamp_farm_n  = farm_light;
        if (!fault || clear_ok) begin
            if (violation) begin
                fault_n      = 1'b1;
                fault_code_n = cause;
                flash_cnt_n  = '0;
                lamp_hw_n    = RED;
                lamp_farm_n  = RED;
            end else begin
                fault_n      = 1'b0;
                fault_code_n = 3'd0;
                flash_cnt_n  = '0;
            end
        end else begin
            flash_cnt_n = (flash_cnt == FLASH_LAST) ? '0 : flash_cnt + 1'b1;
            lamp_hw_n   = (flash_cnt_n < FLASH_MID) ? RED : BAD;
            lamp_farm_n = lamp_hw_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault        <= 1'b0;
            fault_code   <= 3'd0;
            lamp_highway <= RED;
            lamp_farm    <= RED;
            prev_hw      <= RED;
            prev_farm    <= RED;
            yel_cnt_hw   <= '0;
            yel_cnt_farm <= '0;
            flash_cnt    <= '0;
        end else begin
            fault        <= fault_n;
            fault_code   <= fault_code_n;
            lamp_highway <= lamp_hw_n;
            lamp_farm    <= lamp_farm_n;
            prev_hw      <= highway_light;
            prev_farm    <= farm_light;
            flash_cnt    <= flash_cnt_n;
            yel_cnt_hw   <= (highway_light != YELLOW) ? '0 :
                            (yel_cnt_hw == YEL_MAX) ? yel_cnt_hw : yel_cnt_hw + 1'b1;
            yel_cnt_farm <= (farm_light != YELLOW) ? '0 :
                            (yel_cnt_farm == YEL_MAX) ? yel_cnt_farm : yel_cnt_farm + 1'b1;
        end
    end

endmodule

// File: tb/tb_traffic_light_conflict_monitor.sv
// Directed plus randomized bench for traffic_light_conflict_monitor, checked
// against an integer-level model of the monitoring rules.
module tb_traffic_light_conflict_monitor;

    localparam int MIN_YELLOW = 20;
    localparam int FLASH_HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] highway_light = 2'b10;
    logic [1:0] farm_light = 2'b10;
    logic       fault_clear = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] lamp_highway;
    logic [1:0] lamp_farm;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, kept as plain integers
    int m_fault, m_code, m_since_fault;
    int m_prev_hw, m_prev_farm, m_yel_run_hw, m_yel_run_farm;
    int m_lamp_hw, m_lamp_farm;

    traffic_light_conflict_monitor #(
        .MIN_YELLOW(MIN_YELLOW),
        .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .highway_light(highway_light),
        .farm_light(farm_light),
        .fault_clear(fault_clear),
        .fault(fault),
        .fault_code(fault_code),
        .lamp_highway(lamp_highway),
        .lamp_farm(lamp_farm)
    );

    always #5 clk = ~clk;

    function automatic bit bad_step(input int from, input int to);
        return (from == 0 && to == 2) || (from == 1 && to == 0) || (from == 2 && to == 1);
    endfunction

    task automatic model_reset();
        m_fault = 0; m_code = 0; m_since_fault = 0;
        m_prev_hw = 2; m_prev_farm = 2;
        m_yel_run_hw = 0; m_yel_run_farm = 0;
        m_lamp_hw = 2; m_lamp_farm = 2;
    endtask

    task automatic model_step(input int hw, input int fm, input int clr);
        int cause;
        bit clear_ok;
        cause = 0;
        if (hw == 3 || fm == 3) cause = 1;
        else if (hw != 2 && fm != 2) cause = 2;
        else if (bad_step(m_prev_hw, hw)) cause = 3;
        else if (bad_step(m_prev_farm, fm)) cause = 4;
        else if (m_prev_hw == 1 && hw == 2 && m_yel_run_hw < MIN_YELLOW) cause = 5;
        else if (m_prev_farm == 1 && fm == 2 && m_yel_run_farm < MIN_YELLOW) cause = 6;
        clear_ok = (m_fault == 1) && (clr == 1) && hw == 2 && fm == 2;
        m_yel_run_hw   = (hw == 1) ? m_yel_run_hw + 1 : 0;
        m_yel_run_farm = (fm == 1) ? m_yel_run_farm + 1 : 0;
        m_prev_hw = hw;
        m_prev_farm = fm;
        if (m_fault == 0 || clear_ok) begin
            if (cause != 0) begin
                m_fault = 1; m_code = cause; m_since_fault = 0;
            end else begin
                m_fault = 0; m_code = 0;
                m_lamp_hw = hw; m_lamp_farm = fm;
            end
        end else begin
            m_since_fault++;
        end
        if (m_fault == 1) begin
            m_lamp_hw = ((m_since_fault / FLASH_HALF) % 2 == 0) ? 2 : 3;
            m_lamp_farm = m_lamp_hw;
        end
    endtask

    task automatic check_output(input string tag);
        vectors++;
        assert (fault === 1'(m_fault)) else begin
            miscompares++;
            $error("[TB] FAIL %s fault: observed %0b expected %0d", tag, fault, m_fault);
        end
        assert (fault_code === 3'(m_code)) else begin
            miscompares++;
            $error("[TB] FAIL %s fault_code: observed %0d expected %0d", tag, fault_code, m_code);
        end
        assert (lamp_highway === 2'(m_lamp_hw)) else begin
            miscompares++;
            $error("[TB] FAIL %s lamp_highway: observed %b expected %0d", tag, lamp_highway, m_lamp_hw);
        end
        assert (lamp_farm === 2'(m_lamp_farm)) else begin
            miscompares++;
            $error("[TB] FAIL %s lamp_farm: observed %b expected %0d", tag, lamp_farm, m_lamp_farm);
        end
    endtask

    // Direct comparison against constants taken from the test plan
    task automatic expect_state(input string tag, input logic f, input logic [2:0] c,
                                input logic [1:0] lh, input logic [1:0] lf);
        vectors++;
        assert (fault === f && fault_code === c && lamp_highway === lh && lamp_farm === lf) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed fault=%0b code=%0d lamps=%b/%b expected fault=%0b code=%0d lamps=%b/%b",
                   tag, fault, fault_code, lamp_highway, lamp_farm, f, c, lh, lf);
        end
    endtask

    task automatic apply_stimulus(input int hw, input int fm, input int clr, input string tag);
        highway_light = 2'(hw);
        farm_light = 2'(fm);
        fault_clear = 1'(clr);
        @(posedge clk);
        #1;
        model_step(hw, fm, clr);
        check_output(tag);
    endtask

    task automatic hold(input int hw, input int fm, input int clr, input int n, input string tag);
        for (int i = 0; i < n; i++) apply_stimulus(hw, fm, clr, tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_output(tag);
        expect_state({tag, "_const"}, 1'b0, 3'd0, 2'b10, 2'b10);
        rst = 1'b0;
    endtask

    initial begin
        int cur_hw, cur_farm, r;
        model_reset();
        highway_light = 2'b00;
        farm_light = 2'b00;
        do_reset("reset");

        // 1. Normal full cycle
        hold(0, 2, 0, 30, "normal_hw_green");
        hold(1, 2, 0, 21, "normal_hw_yellow");
        hold(2, 0, 0, 30, "normal_farm_green");
        hold(2, 1, 0, 21, "normal_farm_yellow");
        hold(2, 2, 0, 1, "normal_all_red");
        hold(0, 2, 0, 3, "normal_hw_green2");
        expect_state("normal_no_fault", 1'b0, 3'd0, 2'b00, 2'b10);

        // 2. Conflict then flash pattern
        apply_stimulus(0, 0, 0, "conflict");
        expect_state("conflict_code", 1'b1, 3'd2, 2'b10, 2'b10);
        hold(2, 2, 0, 7, "flash_red");
        expect_state("flash_red_end", 1'b1, 3'd2, 2'b10, 2'b10);
        apply_stimulus(2, 2, 0, "flash_dark");
        expect_state("flash_dark_start", 1'b1, 3'd2, 2'b11, 2'b11);
        hold(2, 2, 0, 20, "flash_repeat");
        apply_stimulus(2, 2, 1, "conflict_clear");
        expect_state("conflict_cleared", 1'b0, 3'd0, 2'b10, 2'b10);

        // 3. Short yellow and exact minimum yellow
        hold(0, 2, 0, 3, "sy_green");
        hold(1, 2, 0, MIN_YELLOW - 1, "sy_yellow19");
        apply_stimulus(2, 2, 0, "sy_red");
        expect_state("short_yellow", 1'b1, 3'd5, 2'b10, 2'b10);
        apply_stimulus(2, 2, 1, "sy_clear");
        hold(0, 2, 0, 3, "my_green");
        hold(1, 2, 0, MIN_YELLOW, "my_yellow20");
        apply_stimulus(2, 2, 0, "my_red");
        expect_state("min_yellow_ok", 1'b0, 3'd0, 2'b10, 2'b10);

        // 4. Illegal sequence, invalid code, priority
        hold(2, 0, 0, 3, "seq_farm_green");
        apply_stimulus(2, 2, 0, "seq_farm_jump");
        expect_state("seq_farm", 1'b1, 3'd4, 2'b10, 2'b10);
        apply_stimulus(2, 2, 1, "seq_clear");
        apply_stimulus(3, 2, 0, "invalid_hw");
        expect_state("invalid", 1'b1, 3'd1, 2'b10, 2'b10);
        apply_stimulus(2, 2, 1, "invalid_clear");
        apply_stimulus(3, 0, 0, "invalid_priority");
        expect_state("priority", 1'b1, 3'd1, 2'b10, 2'b10);
        apply_stimulus(2, 2, 1, "clear_vs_seq_farm");
        expect_state("violation_wins_farm", 1'b1, 3'd4, 2'b10, 2'b10);
        apply_stimulus(2, 2, 1, "priority_clear");

        // 5. Clear handling
        apply_stimulus(0, 2, 0, "cl_green");
        apply_stimulus(0, 0, 0, "cl_conflict");
        apply_stimulus(0, 2, 1, "cl_nonred");
        expect_state("clear_ignored", 1'b1, 3'd2, 2'b10, 2'b10);
        apply_stimulus(2, 2, 1, "cl_with_seq");
        expect_state("clear_loses", 1'b1, 3'd3, 2'b10, 2'b10);
        hold(2, 2, 0, 3, "cl_hold");
        apply_stimulus(2, 2, 1, "cl_accept");
        expect_state("clear_ok", 1'b0, 3'd0, 2'b10, 2'b10);
        apply_stimulus(2, 2, 1, "cl_idle");

        // 6. Reset during dark phase
        apply_stimulus(0, 2, 0, "rs_green");
        apply_stimulus(0, 0, 0, "rs_conflict");
        hold(2, 2, 0, 10, "rs_flash");
        expect_state("rs_dark", 1'b1, 3'd2, 2'b11, 2'b11);
        do_reset("reset_mid_flash");
        apply_stimulus(1, 2, 0, "rs_prev_red");
        expect_state("rs_prev_check", 1'b1, 3'd3, 2'b10, 2'b10);
        do_reset("reset2");

        // Randomized walk: mostly legal steps, occasional glitches, clears and resets
        cur_hw = 2;
        cur_farm = 2;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r >= 85 && r < 97) begin
                if ($urandom_range(0, 1) == 0) cur_hw = (cur_hw + 1) % 3;
                else cur_farm = (cur_farm + 1) % 3;
            end else if (r >= 97) begin
                if ($urandom_range(0, 1) == 0) cur_hw = $urandom_range(0, 3);
                else cur_farm = $urandom_range(0, 3);
            end
            if (cur_hw == 3 && $urandom_range(0, 1) == 0) cur_hw = 2;
            if (cur_farm == 3 && $urandom_range(0, 1) == 0) cur_farm = 2;
            if ($urandom_range(0, 599) == 0) do_reset("rand_reset");
            else apply_stimulus(cur_hw, cur_farm, ($urandom_range(0, 3) == 0) ? 1 : 0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
